keypad_ctrl: RTL and testbench

Scan-and-debounce controller for the 4x4 matrix keypad feeding the two-digit multiplexed seven-segment display. It drives the keypad columns one at a time and samples the rows. It debounces a press and its release, and emits exactly one key event per physical press. It keeps the two most recent hex digits (newest and previous) for the display mux. It sits between the keypad pins and the display datapath, and replaces ad hoc scanning and digit shifting in the top level.

---
 rtl/keypad_ctrl.sv | 179 +++++++++++++++++
 tb/tb_keypad_ctrl.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/keypad_ctrl.sv
// keypad_ctrl: 4x4 matrix keypad scanner with press/release debounce and a two-digit history.
// Optional auto-repeat while a key is held: define KEYPAD_REPEAT_EN.
module keypad_ctrl #(
  parameter int SCAN_CYCLES     = 50000,
  parameter int DEBOUNCE_CYCLES = 1000000
`ifdef KEYPAD_REPEAT_EN
  , parameter int REPEAT_CYCLES = 24000000
`endif
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] rows,
  output logic [3:0] cols,
  output logic       key_valid,
  output logic [3:0] key_code,
  output logic [3:0] digit_new,
  output logic [3:0] digit_old
);

  // state    | meaning
  // SCAN     | drive one column per dwell, sample rows at the end of the dwell
  // DEBOUNCE | candidate key found, waiting for a stable low on its row
  // HELD     | key accepted, waiting for its row to go high
  // RELEASE  | row high, waiting for a stable release
  typedef enum logic [1:0] {SCAN, DEBOUNCE, HELD, RELEASE} state_t;

  localparam int DW = $clog2(SCAN_CYCLES);
  localparam int BW = $clog2(DEBOUNCE_CYCLES);

  state_t          state, state_nxt;
  logic [1:0]      col, col_nxt;
  logic [1:0]      row, row_nxt;
  logic [1:0]      low_row;
  logic [DW-1:0]   dwell, dwell_nxt;
  logic [BW-1:0]   cnt, cnt_nxt, cnt_inc;
  logic [3:0]      rows_m, rows_s;
  logic [3:0]      code;
  logic            row_low;
  logic            emit;
`ifdef KEYPAD_REPEAT_EN
  localparam int RW = $clog2(REPEAT_CYCLES);
  logic [RW-1:0]   rpt, rpt_nxt;
`endif

  function automatic logic [3:0] keymap(input logic [1:0] r, input logic [1:0] c);
    keymap = 4'h0;
    case ({r, c})
      4'h0: keymap = 4'h1;
      4'h1: keymap = 4'h2;
      4'h2: keymap = 4'h3;
      4'h3: keymap = 4'hA;
      4'h4: keymap = 4'h4;
      4'h5: keymap = 4'h5;
      4'h6: keymap = 4'h6;
      4'h7: keymap = 4'hB;
      4'h8: keymap = 4'h7;
      4'h9: keymap = 4'h8;
      4'hA: keymap = 4'h9;
      4'hB: keymap = 4'hC;
      4'hC: keymap = 4'hE;
      4'hD: keymap = 4'h0;
      4'hE: keymap = 4'hF;
      4'hF: keymap = 4'hD;
      default: keymap = 4'h0;
    endcase
  endfunction

  assign cols = ~(4'b0001 << col);
  assign code = keymap(row, col);

  always_comb begin
    state_nxt = state;
    col_nxt   = col;
    row_nxt   = row;
    dwell_nxt = dwell;
    cnt_nxt   = cnt;
    emit      = 1'b0;
    row_low   = ~rows_s[row];
    cnt_inc   = (cnt == BW'(DEBOUNCE_CYCLES - 1)) ? cnt : cnt + BW'(1);
`ifdef KEYPAD_REPEAT_EN
    rpt_nxt   = '0;
`endif
    if (!rows_s[0])      low_row = 2'd0;
    else if (!rows_s[1]) low_row = 2'd1;
    else if (!rows_s[2]) low_row = 2'd2;
    else                 low_row = 2'd3;

    // The low sample taken in SCAN counts as the first debounce sample,
    // so DEBOUNCE/RELEASE finish when the counter reaches DEBOUNCE_CYCLES-2.
    case (state)
      SCAN: begin
        if (dwell == DW'(SCAN_CYCLES - 1)) begin
          dwell_nxt = '0;
          if (rows_s != 4'hF) begin
            row_nxt   = low_row;
            cnt_nxt   = '0;
            state_nxt = DEBOUNCE;
          end else begin
            col_nxt = col + 2'd1;
          end
        end else begin
          dwell_nxt = dwell + DW'(1);
        end
      end
      DEBOUNCE: begin
        if (!row_low) begin
          col_nxt   = col + 2'd1;
          dwell_nxt = '0;
          state_nxt = SCAN;
        end else if (cnt == BW'(DEBOUNCE_CYCLES - 2)) begin
          emit      = 1'b1;
          state_nxt = HELD;
        end else begin
          cnt_nxt = cnt_inc;
        end
      end
      HELD: begin
        if (!row_low) begin
          cnt_nxt   = '0;
          state_nxt = RELEASE;
        end else begin
`ifdef KEYPAD_REPEAT_EN
          if (rpt == RW'(REPEAT_CYCLES - 1)) emit = 1'b1;
          else                              rpt_nxt = rpt + RW'(1);
`endif
        end
      end
      RELEASE: begin
        if (row_low) begin
          state_nxt = HELD;
        end else if (cnt == BW'(DEBOUNCE_CYCLES - 2)) begin
          col_nxt   = col + 2'd1;
          dwell_nxt = '0;
          state_nxt = SCAN;
        end else begin
          cnt_nxt = cnt_inc;
        end
      end
      default: state_nxt = SCAN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state     <= SCAN;
      col       <= '0;
      row       <= '0;
      dwell     <= '0;
      cnt       <= '0;
      rows_m    <= 4'hF;
      rows_s    <= 4'hF;
      key_valid <= 1'b0;
      key_code  <= 4'h0;
      digit_new <= 4'h0;
      digit_old <= 4'h0;
`ifdef KEYPAD_REPEAT_EN
      rpt       <= '0;
`endif
    end else begin
      state     <= state_nxt;
      col       <= col_nxt;
      row       <= row_nxt;
      dwell     <= dwell_nxt;
      cnt       <= cnt_nxt;
      rows_m    <= rows;
      rows_s    <= rows_m;
      key_valid <= emit;
      if (emit) begin
        key_code  <= code;
        digit_new <= code;
        digit_old <= digit_new;
      end
`ifdef KEYPAD_REPEAT_EN
      rpt       <= rpt_nxt;
`endif
    end
  end

endmodule

// File: tb/tb_keypad_ctrl.sv
// tb_keypad_ctrl: directed checks of keypad_ctrl with a behavioural single-key matrix model.
// Cycle 0 is the cycle after the last edge that samples reset low.
module tb_keypad_ctrl;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [3:0] rows;
  logic [3:0] cols;
  logic       key_valid;
  logic [3:0] key_code;
  logic [3:0] digit_new;
  logic [3:0] digit_old;

  logic       key_down = 1'b0;
  logic [1:0] key_r = 2'd0;
  logic [1:0] key_c = 2'd0;
  logic [3:0] col_seq [4];

  int cyc = 0;
  int pulses = 0;
  int last_pulse = -1;
  int prev_pulse = -1;
  int n_checks = 0;
  int n_fail = 0;

  keypad_ctrl #(
    .SCAN_CYCLES(4),
    .DEBOUNCE_CYCLES(8)
`ifdef KEYPAD_REPEAT_EN
    , .REPEAT_CYCLES(32)
`endif
  ) dut (
    .clk(clk),
    .reset(reset),
    .rows(rows),
    .cols(cols),
    .key_valid(key_valid),
    .key_code(key_code),
    .digit_new(digit_new),
    .digit_old(digit_old)
  );

  always #5 clk = ~clk;

  // A pressed key pulls its row low only while its column is driven.
  always_comb rows = (key_down && !cols[key_c]) ? ~(4'b0001 << key_r) : 4'hF;

  always @(posedge clk) cyc <= reset ? cyc + 1 : 0;

  always @(negedge clk) begin
    if (!reset) begin
      pulses = 0;
      last_pulse = -1;
      prev_pulse = -1;
    end else if (key_valid) begin
      pulses = pulses + 1;
      prev_pulse = last_pulse;
      last_pulse = cyc;
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic at_cyc(input int k);
    while (cyc < k) @(negedge clk);
  endtask

  task automatic do_reset();
    key_down = 1'b0;
    reset = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
  endtask

  task automatic press(input logic [1:0] r, input logic [1:0] c);
    key_r = r;
    key_c = c;
    key_down = 1'b1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    col_seq = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};

    // idle scan
    do_reset();
    chk("rst cols", cols, 4'b1110);
    chk("rst key_valid", key_valid, 1'b0);
    chk("rst key_code", key_code, 4'h0);
    chk("rst digit_new", digit_new, 4'h0);
    chk("rst digit_old", digit_old, 4'h0);
    for (int i = 0; i < 10; i++) begin
      at_cyc(4 * i);
      chk($sformatf("idle cols %0d", i), cols, col_seq[i % 4]);
    end
    at_cyc(40);
    chk("idle pulses", pulses, 0);

    // '5' held 30 cycles: sample at 7, pulse at 15
    do_reset();
    press(2'd1, 2'd1);
    at_cyc(15);
    chk("k5 key_valid", key_valid, 1'b1);
    chk("k5 key_code", key_code, 4'h5);
    chk("k5 digit_new", digit_new, 4'h5);
    chk("k5 digit_old", digit_old, 4'h0);
    at_cyc(16);
    chk("k5 pulse width", key_valid, 1'b0);
    at_cyc(29);
    chk("k5 pulses", pulses, 1);
    chk("k5 pulse cycle", last_pulse, 15);
    chk("k5 cols held", cols, 4'b1101);
    at_cyc(30);
    key_down = 1'b0;
    at_cyc(39);
    chk("k5 cols in release", cols, 4'b1101);
    at_cyc(40);
    chk("k5 cols after release", cols, 4'b1011);

    // '7', release, then 'D'
    do_reset();
    press(2'd2, 2'd0);
    at_cyc(12);
    chk("k7 digit_new", digit_new, 4'h7);
    chk("k7 key_code", key_code, 4'h7);
    at_cyc(20);
    key_down = 1'b0;
    at_cyc(30);
    chk("k7 cols after release", cols, 4'b1101);
    chk("k7 key_code holds", key_code, 4'h7);
    press(2'd3, 2'd3);
    at_cyc(60);
    chk("kD pulses", pulses, 2);
    chk("kD pulse cycle", last_pulse, 49);
    chk("kD key_code", key_code, 4'hD);
    chk("kD digit_new", digit_new, 4'hD);
    chk("kD digit_old", digit_old, 4'h7);

    // '9' bouncing every 3 cycles from cycle 7, stable low from cycle 25
    do_reset();
    key_r = 2'd2;
    key_c = 2'd2;
    for (int k = 7; k < 27; k++) begin
      at_cyc(k);
      key_down = (((k - 7) / 3) % 2) == 0;
      if (k == 12) chk("k9 cols in debounce", cols, 4'b1011);
      if (k == 13) chk("k9 cols after abandon", cols, 4'b0111);
    end
    key_down = 1'b1;
    at_cyc(50);
    chk("k9 pulses", pulses, 1);
    chk("k9 pulse cycle", last_pulse, 36);
    chk("k9 key_code", key_code, 4'h9);

    // 'A' with a 5-cycle release glitch
    do_reset();
    press(2'd0, 2'd3);
    at_cyc(30);
    key_down = 1'b0;
    at_cyc(35);
    key_down = 1'b1;
    at_cyc(36);
    chk("kA cols in glitch", cols, 4'b0111);
    at_cyc(60);
    chk("kA glitch pulses", pulses, 1);
    chk("kA pulse cycle", last_pulse, 23);
    chk("kA key_code", key_code, 4'hA);

    // 'A' held for 100 cycles after its first event
    do_reset();
    press(2'd0, 2'd3);
    at_cyc(123);
    key_down = 1'b0;
    at_cyc(140);
`ifdef KEYPAD_REPEAT_EN
    chk("long hold pulses", pulses, 4);
    chk("long hold last", last_pulse, 119);
    chk("long hold prev", prev_pulse, 87);
`else
    chk("long hold pulses", pulses, 1);
    chk("long hold last", last_pulse, 23);
`endif

    // reset while HELD on '3' with history 7 -> 3
    do_reset();
    press(2'd2, 2'd0);
    at_cyc(20);
    key_down = 1'b0;
    at_cyc(30);
    press(2'd0, 2'd2);
    at_cyc(50);
    chk("k3 pulse cycle", last_pulse, 45);
    chk("k3 digit_new", digit_new, 4'h3);
    chk("k3 digit_old", digit_old, 4'h7);
    chk("k3 cols held", cols, 4'b1011);
    reset = 1'b0;
    @(posedge clk);
    #1;
    chk("mid rst cols", cols, 4'b1110);
    chk("mid rst key_valid", key_valid, 1'b0);
    chk("mid rst key_code", key_code, 4'h0);
    chk("mid rst digit_new", digit_new, 4'h0);
    chk("mid rst digit_old", digit_old, 4'h0);
    reset = 1'b1;
    key_down = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
